// File: rtl/lobinho_pkg.sv
// Shared definitions for the werewolf game target selector: player class codes,
// selector state encodings and the default player count.
package lobinho_pkg;

    // Class of the acting player
    localparam logic [1:0] CLASSE_ALDEAO   = 2'b00;
    localparam logic [1:0] CLASSE_LOBO     = 2'b01;
    localparam logic [1:0] CLASSE_PROTETOR = 2'b10;
    localparam logic [1:0] CLASSE_NENHUMA  = 2'b11;

    // Default number of players
    localparam int N_JOG_PADRAO = 5;

    // Selector states, exported as-is on db_estado
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        ESCOLHE = 3'd2,
        ENVIA   = 3'd3
    } estado_t;

endpackage

// File: rtl/seletor_alvo_if.sv
// Valid/accept hand-off of the chosen target between the selector (master)
// and the game datapath (slave). sem_alvo travels with it so the consumer
// also learns when no target exists.
interface seletor_alvo_if #(
    parameter int W = 3
) ();
    logic [W-1:0] jogador_escolhido;
    logic         escolha_valida;
    logic         sem_alvo;
    logic         aceito;

    modport master (
        output jogador_escolhido,
        output escolha_valida,
        output sem_alvo,
        input  aceito
    );

    modport slave (
        input  jogador_escolhido,
        input  escolha_valida,
        input  sem_alvo,
        output aceito
    );
endinterface

// File: rtl/pulso_botao.sv
// Rising-edge pulse generator for one raw button level. The pulse is high
// only while the level is high and the previous sampled level was low, so a
// held button yields exactly one pulse.
module pulso_botao (
    input  logic clock,
    input  logic reset,
    input  logic nivel_i,
    output logic pulso_o
);
    logic anterior_q;

    // Remember last cycle's level
    always_ff @(posedge clock) begin
        if (reset) begin
            anterior_q <= 1'b0;
        end else begin
            anterior_q <= nivel_i;
        end
    end

    assign pulso_o = nivel_i & ~anterior_q;
endmodule

// File: rtl/seletor_alvo.sv
// Target selector: on iniciar, walks a cursor over eligible players (alive,
// and not the actor unless the actor is the protector), lets the player move
// it with next/previous and confirm, then hands the choice off via
// escolha_valida/aceito. If no player is eligible, sem_alvo pulses once.
// Optional build macro SELECAO_TIMEOUT_EN: auto-confirms the current cursor
// after TIMEOUT idle cycles in ESCOLHE.
module seletor_alvo
    import lobinho_pkg::*;
#(
    parameter int N_JOG = N_JOG_PADRAO,
    parameter int W     = 3
`ifdef SELECAO_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1000
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [1:0]        classe_atual,
    input  logic [W-1:0]      jogador_atual,
    input  logic [N_JOG-1:0]  mortes,
    input  logic              btn_prox,
    input  logic              btn_ant,
    input  logic              btn_conf,
    seletor_alvo_if.master    saida,
    output logic              ocupado,
    output logic [W-1:0]      db_candidato,
    output logic [2:0]        db_estado
);

    // Step counter must be able to hold N_JOG itself
    localparam int CONT_W = $clog2(N_JOG + 1);

    // Button index order inside the pulse vector
    localparam int B_PROX = 0;
    localparam int B_ANT  = 1;
    localparam int B_CONF = 2;

    estado_t           estado_q;
    logic [W-1:0]      cursor_q;
    logic [W-1:0]      escolhido_q;
    logic              valida_q;
    logic              sem_alvo_q;
    logic              dir_neg_q;      // 0 = moving +1, 1 = moving -1
    logic [CONT_W-1:0] contagem_q;
    logic [1:0]        classe_s_q;
    logic [W-1:0]      jogador_s_q;

    logic [2:0]        botoes;
    logic [2:0]        pulsos;
    logic [N_JOG-1:0]  elig_vec;
    logic              elig_cursor;
    logic              conf_efetivo;
    logic              pulso_prox;
    logic              pulso_ant;

    assign botoes = {btn_conf, btn_ant, btn_prox};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_botao
            pulso_botao u_pulso (
                .clock   (clock),
                .reset   (reset),
                .nivel_i (botoes[gi]),
                .pulso_o (pulsos[gi])
            );
        end
    endgenerate

    assign pulso_prox = pulsos[B_PROX];
    assign pulso_ant  = pulsos[B_ANT];

    // Eligibility per player; mortes is live so a death mid-selection is seen
    generate
        for (genvar gi = 0; gi < N_JOG; gi++) begin : g_elig
            assign elig_vec[gi] = ~mortes[gi] &
                                  ~((jogador_s_q == W'(gi)) &
                                    (classe_s_q != CLASSE_PROTETOR));
        end
    endgenerate

    assign elig_cursor = elig_vec[cursor_q];

`ifdef SELECAO_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_q;
    assign conf_efetivo = pulsos[B_CONF] | (tmo_q == TMO_W'(TIMEOUT - 1));
`else
    assign conf_efetivo = pulsos[B_CONF];
`endif

    // Modular cursor step over 0..N_JOG-1 in the given direction
    function automatic logic [W-1:0] passo(input logic [W-1:0] c, input logic neg);
        if (!neg) begin
            return (c == W'(N_JOG - 1)) ? '0 : c + 1'b1;
        end else begin
            return (c == '0) ? W'(N_JOG - 1) : c - 1'b1;
        end
    endfunction

    // Selection FSM with registered hand-off outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            cursor_q    <= '0;
            escolhido_q <= '0;
            valida_q    <= 1'b0;
            sem_alvo_q  <= 1'b0;
            dir_neg_q   <= 1'b0;
            contagem_q  <= '0;
            classe_s_q  <= CLASSE_ALDEAO;
            jogador_s_q <= '0;
`ifdef SELECAO_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            sem_alvo_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (iniciar && (classe_atual != CLASSE_NENHUMA)) begin
                        classe_s_q  <= classe_atual;
                        jogador_s_q <= jogador_atual;
                        cursor_q    <= '0;
                        dir_neg_q   <= 1'b0;
                        contagem_q  <= '0;
                        estado_q    <= BUSCA;
                    end
                end
                BUSCA: begin
                    // A full lap ends with the cursor back on its starting
                    // index, which is checked once more before giving up.
                    if (elig_cursor) begin
                        estado_q <= ESCOLHE;
`ifdef SELECAO_TIMEOUT_EN
                        tmo_q    <= '0;
`endif
                    end else if (contagem_q == CONT_W'(N_JOG)) begin
                        sem_alvo_q <= 1'b1;
                        estado_q   <= OCIOSO;
                    end else begin
                        cursor_q   <= passo(cursor_q, dir_neg_q);
                        contagem_q <= contagem_q + 1'b1;
                    end
                end
                ESCOLHE: begin
                    // A death under the cursor overrides everything, so a
                    // dead player can never be confirmed.
                    if (!elig_cursor) begin
                        contagem_q <= '0;
                        estado_q   <= BUSCA;
                    end else if (conf_efetivo) begin
                        escolhido_q <= cursor_q;
                        valida_q    <= 1'b1;
                        estado_q    <= ENVIA;
                    end else if (pulso_prox && !pulso_ant) begin
                        dir_neg_q  <= 1'b0;
                        cursor_q   <= passo(cursor_q, 1'b0);
                        contagem_q <= CONT_W'(1);
                        estado_q   <= BUSCA;
                    end else if (pulso_ant && !pulso_prox) begin
                        dir_neg_q  <= 1'b1;
                        cursor_q   <= passo(cursor_q, 1'b1);
                        contagem_q <= CONT_W'(1);
                        estado_q   <= BUSCA;
                    end
`ifdef SELECAO_TIMEOUT_EN
                    else if (pulso_prox || pulso_ant) begin
                        tmo_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                ENVIA: begin
                    if (saida.aceito) begin
                        valida_q <= 1'b0;
                        estado_q <= OCIOSO;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign saida.jogador_escolhido = escolhido_q;
    assign saida.escolha_valida    = valida_q;
    assign saida.sem_alvo          = sem_alvo_q;
    assign ocupado                 = (estado_q != OCIOSO);
    assign db_candidato            = cursor_q;
    assign db_estado               = estado_q;

endmodule
